// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised LFSR pattern generator for PRBS / scrambler / self-test use.
// Successor of the fixed 16-bit Fibonacci LFSR. It supports:
//   - a runtime tap mask and Fibonacci/Galois selection
//   - STEPS shifts per enabled cycle, chained combinationally
//   - synchronous seed load and clock enable
//   - all-zero lock-up detection with automatic recovery to DEFAULT_SEED
//   - period measurement against the most recent start value
//
// Parameters:
//   WIDTH        LFSR state width (>= 3)
//   STEPS        shifts applied per enabled cycle (1..WIDTH)
//   DEFAULT_SEED reset / lock-up recovery state (nonzero)
//   CNT_W        width of the period counter and period_len
//
// Ports:
//   clk          clock
//   nReset       asynchronous, active-high reset
//   en           advance the state by STEPS shifts this cycle
//   load         synchronous seed load, overrides en
//   seed         value loaded when load=1
//   taps         feedback tap mask (bit i set = tap on state[i])
//   mode         0 = Fibonacci, 1 = Galois
//   out          current LFSR state (registered)
//   lockup       registered, equals (out == 0)
//   period_done  one-cycle pulse when the state returns to the start value
//   period_len   enabled-cycle count of the last completed period
// -----------------------------------------------------------------------------
module lfsr_gen #(
  parameter int               WIDTH        = 16,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W        = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] taps,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             lockup,
  output logic             period_done,
  output logic [CNT_W-1:0] period_len
);

  // Per-cycle action, resolved with priority load > en > hold.
  localparam logic [1:0] ACT_HOLD    = 2'd0;
  localparam logic [1:0] ACT_LOAD    = 2'd1;
  localparam logic [1:0] ACT_RECOVER = 2'd2;
  localparam logic [1:0] ACT_SHIFT   = 2'd3;

  localparam logic [WIDTH-1:0] ZERO_STATE = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Even/odd parity of a tap-masked state: the Fibonacci feedback bit.
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // One LFSR shift in the selected structure.
  function automatic logic [WIDTH-1:0] lfsr_shift(
    input logic [WIDTH-1:0] s,
    input logic [WIDTH-1:0] t,
    input logic             m
  );
    logic [WIDTH-1:0] r;
    if (m == 1'b0) begin
      r = {s[WIDTH-2:0], parity_of(s & t)};
    end else begin
      // Galois: the bit shifted out of the MSB is folded into every tap.
      r = (s << 1) ^ (t & {WIDTH{s[WIDTH-1]}});
    end
    return r;
  endfunction

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] start_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] plen_r;
  logic             pdone_r;
  logic             lockup_r;

  logic [1:0]       act_s;
  logic [WIDTH-1:0] chain_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [WIDTH-1:0] state_nxt_s;
  logic [WIDTH-1:0] start_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] plen_nxt_s;
  logic             pdone_nxt_s;

  // Select this cycle's action from load/en and the lock-up condition.
  always_comb begin
    act_s = ACT_HOLD;
    if (load) begin
      act_s = ACT_LOAD;
    end else if (en) begin
      if (state_r == ZERO_STATE) begin
        act_s = ACT_RECOVER;
      end else begin
        act_s = ACT_SHIFT;
      end
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Chain STEPS single shifts; taps/mode are sampled for this cycle only.
  always_comb begin
    chain_s = state_r;
    for (int i = 0; i < STEPS; i++) begin
      chain_s = lfsr_shift(chain_s, taps, mode);
    end
  end

  // Saturating increment of the enabled-cycle counter.
  always_comb begin
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // Next-state for state, start value, counter and period outputs.
  always_comb begin
    state_nxt_s = state_r;
    start_nxt_s = start_r;
    cnt_nxt_s   = cnt_r;
    plen_nxt_s  = plen_r;
    pdone_nxt_s = 1'b0;
    case (act_s)
      ACT_LOAD: begin
        state_nxt_s = seed;
        start_nxt_s = seed;
        cnt_nxt_s   = CNT_ZERO;
        pdone_nxt_s = 1'b0;
      end
      ACT_RECOVER: begin
        // All-zero is a fixed point of every tap mask; restart instead.
        state_nxt_s = DEFAULT_SEED;
        start_nxt_s = DEFAULT_SEED;
        cnt_nxt_s   = CNT_ZERO;
        pdone_nxt_s = 1'b0;
      end
      ACT_SHIFT: begin
        state_nxt_s = chain_s;
        if (chain_s == start_r) begin
          // Match only at cycle granularity; intra-cycle returns are missed.
          pdone_nxt_s = 1'b1;
          plen_nxt_s  = cnt_inc_s;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          pdone_nxt_s = 1'b0;
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      ACT_HOLD: begin
        pdone_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = state_r;
        start_nxt_s = start_r;
        cnt_nxt_s   = cnt_r;
        plen_nxt_s  = plen_r;
        pdone_nxt_s = 1'b0;
      end
    endcase
  end

  // State registers; lockup is derived from the next state so it tracks out.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      state_r  <= DEFAULT_SEED;
      start_r  <= DEFAULT_SEED;
      cnt_r    <= CNT_ZERO;
      plen_r   <= CNT_ZERO;
      pdone_r  <= 1'b0;
      lockup_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      start_r  <= start_nxt_s;
      cnt_r    <= cnt_nxt_s;
      plen_r   <= plen_nxt_s;
      pdone_r  <= pdone_nxt_s;
      lockup_r <= (state_nxt_s == ZERO_STATE);
    end
  end

  assign out         = state_r;
  assign lockup      = lockup_r;
  assign period_done = pdone_r;
  assign period_len  = plen_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
// Self-checking bench for lfsr_gen. Two instances share the stimulus:
// dut1 with STEPS=1 and dut2 with STEPS=2. A behavioural model of each,
// written with plain arithmetic, runs alongside for the randomized test.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

  logic        clk;
  logic        nReset;
  logic        en;
  logic        load;
  logic [15:0] seed;
  logic [15:0] taps;
  logic        mode;

  logic [15:0] out1, out2;
  logic        lock1, lock2;
  logic        pd1, pd2;
  logic [31:0] plen1, plen2;

  int checks   = 0;
  int failures = 0;

  // Model state, index 0 -> STEPS=1, index 1 -> STEPS=2.
  logic [15:0] m_out   [2];
  logic [15:0] m_start [2];
  logic [31:0] m_cnt   [2];
  logic [31:0] m_plen  [2];
  logic        m_pd    [2];

  lfsr_gen #(.WIDTH(16), .STEPS(1), .DEFAULT_SEED(16'h0001), .CNT_W(32)) dut1 (
    .clk(clk), .nReset(nReset), .en(en), .load(load), .seed(seed),
    .taps(taps), .mode(mode), .out(out1), .lockup(lock1),
    .period_done(pd1), .period_len(plen1)
  );

  lfsr_gen #(.WIDTH(16), .STEPS(2), .DEFAULT_SEED(16'h0001), .CNT_W(32)) dut2 (
    .clk(clk), .nReset(nReset), .en(en), .load(load), .seed(seed),
    .taps(taps), .mode(mode), .out(out2), .lockup(lock2),
    .period_done(pd2), .period_len(plen2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One shift as arithmetic: doubling modulo 2^16 plus feedback.
  function automatic logic [15:0] ref_shift(input logic [15:0] s, input logic [15:0] t,
                                            input logic m);
    int v;
    v = (int'(s) * 2) % 65536;
    if (m == 1'b0) begin
      v = v + ($countones(s & t) % 2);
    end else if (int'(s) >= 32768) begin
      v = v ^ int'(t);
    end
    return 16'(v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 16'h0001; m_start[k] = 16'h0001;
      m_cnt[k] = 32'd0; m_plen[k] = 32'd0; m_pd[k] = 1'b0;
    end
  endtask

  // Apply one clock of the behavioural rules to both models.
  task automatic model_clock();
    logic [15:0] nx;
    logic [31:0] c;
    if (nReset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (load) begin
          m_out[k] = seed; m_start[k] = seed; m_cnt[k] = 32'd0; m_pd[k] = 1'b0;
        end else if (en && m_out[k] == 16'h0000) begin
          m_out[k] = 16'h0001; m_start[k] = 16'h0001; m_cnt[k] = 32'd0; m_pd[k] = 1'b0;
        end else if (en) begin
          nx = m_out[k];
          for (int s = 0; s <= k; s++) nx = ref_shift(nx, taps, mode);
          c = (m_cnt[k] == 32'hFFFF_FFFF) ? m_cnt[k] : m_cnt[k] + 32'd1;
          if (nx == m_start[k]) begin
            m_pd[k] = 1'b1; m_plen[k] = c; m_cnt[k] = 32'd0;
          end else begin
            m_pd[k] = 1'b0; m_cnt[k] = c;
          end
          m_out[k] = nx;
        end else begin
          m_pd[k] = 1'b0;
        end
      end
    end
  endtask

  // Advance one clock; outputs are stable when this returns (#1 after edge).
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b1; en = 1'b0; load = 1'b0; seed = 16'h0000;
    taps = 16'hB400; mode = 1'b0;
    tick(); tick();
    nReset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out1 !== 16'h0001)  begin failures++; $display("FAIL reset_out1 got %h exp 0001", out1); end
    checks++; if (out2 !== 16'h0001)  begin failures++; $display("FAIL reset_out2 got %h exp 0001", out2); end
    checks++; if (lock1 !== 1'b0 || pd1 !== 1'b0) begin failures++; $display("FAIL reset_flags got lock=%b pd=%b exp 0 0", lock1, pd1); end
    checks++; if (plen1 !== 32'd0)    begin failures++; $display("FAIL reset_plen got %0d exp 0", plen1); end
  endtask

  task automatic test_fib_sequence();
    do_reset();
    taps = 16'hB400; mode = 1'b0; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1)  begin checks++; if (out1 !== 16'h0002) begin failures++; $display("FAIL fib_c1 got %h exp 0002", out1); end end
      if (i == 10) begin checks++; if (out1 !== 16'h0400) begin failures++; $display("FAIL fib_c10 got %h exp 0400", out1); end end
      if (i == 11) begin checks++; if (out1 !== 16'h0801) begin failures++; $display("FAIL fib_c11 got %h exp 0801", out1); end end
      if (i == 12) begin checks++; if (out1 !== 16'h1002) begin failures++; $display("FAIL fib_c12 got %h exp 1002", out1); end end
    end
    en = 1'b0;
  endtask

  task automatic test_full_period();
    int early;
    early = 0;
    do_reset();
    taps = 16'hB400; mode = 1'b0; en = 1'b1;
    for (int c = 1; c <= 65535; c++) begin
      tick();
      if (c < 65535 && pd1 !== 1'b0) early++;
      if (pd2 !== m_pd[1]) early++;
    end
    en = 1'b0;
    checks++; if (early != 0)      begin failures++; $display("FAIL period_early got %0d stray pulses exp 0", early); end
    checks++; if (pd1 !== 1'b1)    begin failures++; $display("FAIL period_pulse got %b exp 1", pd1); end
    checks++; if (out1 !== 16'h0001) begin failures++; $display("FAIL period_out got %h exp 0001", out1); end
    checks++; if (plen1 !== 32'd65535) begin failures++; $display("FAIL period_len got %0d exp 65535", plen1); end
    tick();
    checks++; if (pd1 !== 1'b0)    begin failures++; $display("FAIL period_pulse_width got %b exp 0", pd1); end
  endtask

  task automatic test_galois();
    load = 1'b1; seed = 16'h8000; taps = 16'h002D; mode = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++; if (out1 !== 16'h002D) begin failures++; $display("FAIL galois_c1 got %h exp 002D", out1); end
    tick();
    checks++; if (out1 !== 16'h005A) begin failures++; $display("FAIL galois_c2 got %h exp 005A", out1); end
    checks++; if (out2 !== m_out[1]) begin failures++; $display("FAIL galois_steps2 got %h exp %h", out2, m_out[1]); end
    en = 1'b0;
  endtask

  task automatic test_steps2();
    load = 1'b1; seed = 16'h0001; taps = 16'hB400; mode = 1'b0; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) begin checks++; if (out2 !== 16'h0400) begin failures++; $display("FAIL steps2_c5 got %h exp 0400", out2); end end
      if (i == 6) begin checks++; if (out2 !== 16'h1002) begin failures++; $display("FAIL steps2_c6 got %h exp 1002", out2); end end
    end
    en = 1'b0;
  endtask

  task automatic test_lockup();
    load = 1'b1; seed = 16'h0000; en = 1'b0;
    tick();
    load = 1'b0;
    tick();
    checks++; if (out1 !== 16'h0000 || lock1 !== 1'b1) begin failures++; $display("FAIL lockup_hold got out=%h lock=%b exp 0000 1", out1, lock1); end
    checks++; if (lock2 !== 1'b1) begin failures++; $display("FAIL lockup_hold2 got %b exp 1", lock2); end
    en = 1'b1;
    tick();
    checks++; if (out1 !== 16'h0001 || lock1 !== 1'b0 || pd1 !== 1'b0) begin
      failures++; $display("FAIL lockup_recover got out=%h lock=%b pd=%b exp 0001 0 0", out1, lock1, pd1); end
    checks++; if (out2 !== 16'h0001) begin failures++; $display("FAIL lockup_recover2 got %h exp 0001", out2); end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    logic [15:0] frozen;
    int pulses;
    pulses = 0;
    taps = 16'h8000; mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    load = 1'b1; seed = 16'h0001;
    tick();
    load = 1'b0;
    checks++; if (out1 !== 16'h0001) begin failures++; $display("FAIL load_over_en got %h exp 0001", out1); end
    frozen = out1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out1 !== frozen || pd1 !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL hold_frozen got %0d bad cycles exp 0", pulses); end
    // Rotation taps: period 16 (dut1) and 8 (dut2) from a cleared counter.
    en = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (plen1 !== 32'd16) begin failures++; $display("FAIL load_cnt_clear got %0d exp 16", plen1); end
    checks++; if (plen2 !== 32'd8)  begin failures++; $display("FAIL load_cnt_clear2 got %0d exp 8", plen2); end
    for (int i = 0; i < 3; i++) tick();
    #2 nReset = 1'b1;
    #1;
    checks++; if (out1 !== 16'h0001 || plen1 !== 32'd0) begin
      failures++; $display("FAIL async_reset got out=%h plen=%0d exp 0001 0", out1, plen1); end
    tick();
    nReset = 1'b0; en = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 31) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 2))
          0: taps = 16'hB400;
          1: taps = 16'h8000;
          default: taps = 16'($urandom);
        endcase
        mode = 1'($urandom_range(0, 1));
      end
      tick();
      checks++;
      if (out1 !== m_out[0] || lock1 !== (m_out[0] == 16'h0000) || pd1 !== m_pd[0] || plen1 !== m_plen[0]) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL rand_dut1 cyc %0d got out=%h lock=%b pd=%b plen=%0d exp out=%h pd=%b plen=%0d",
                               c, out1, lock1, pd1, plen1, m_out[0], m_pd[0], m_plen[0]);
      end
      checks++;
      if (out2 !== m_out[1] || lock2 !== (m_out[1] == 16'h0000) || pd2 !== m_pd[1] || plen2 !== m_plen[1]) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL rand_dut2 cyc %0d got out=%h lock=%b pd=%b plen=%0d exp out=%h pd=%b plen=%0d",
                               c, out2, lock2, pd2, plen2, m_out[1], m_pd[1], m_plen[1]);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  initial begin
    nReset = 1'b1; en = 1'b0; load = 1'b0; seed = 16'h0000; taps = 16'h0000; mode = 1'b0;
    model_reset();
    test_reset();
    test_fib_sequence();
    test_full_period();
    test_galois();
    test_steps2();
    test_lockup();
    test_load_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised LFSR generator, next generation of the team's fixed 16-bit Fibonacci LFSR. It adds:
- runtime-programmable tap mask
- Fibonacci/Galois mode select
- multiple shifts per clock
- clock enable and synchronous seed load
- all-zero lock-up detection with auto-recovery
- period measurement

It sits beside datapath blocks as a PRBS/scrambler source and self-test pattern generator.

Parameters:
WIDTH, 16, LFSR state width (>=3)
STEPS, 1, LFSR shifts applied per enabled cycle (1..WIDTH)
DEFAULT_SEED, 16'h0001 (WIDTH bits), state after reset and lock-up recovery value (must be nonzero)
CNT_W, 32, width of period counter and period_len

Ports:
clk  in  1  clock
nReset  in  1  asynchronous, active-high reset
en  in  1  advance state by STEPS shifts this cycle
load  in  1  synchronous load of seed; overrides en
seed  in  WIDTH  value loaded when load=1
taps  in  WIDTH  feedback tap mask (bit i set = tap on state[i])
mode  in  1  0 = Fibonacci, 1 = Galois
out  out  WIDTH  current LFSR state (registered)
lockup  out  1  registered: out == 0
period_done  out  1  one-cycle pulse: state returned to start value
period_len  out  CNT_W  enabled-cycle count of the last completed period

Behaviour:
- Reset (nReset=1, asynchronous, active-high):
  - out=DEFAULT_SEED, internal start register=DEFAULT_SEED
  - period counter=0, period_len=0, lockup=0, period_done=0
- Single shift, Fibonacci: fb = XOR-reduce(state & taps); next = {state[WIDTH-2:0], fb}.
- Single shift, Galois: next = (state << 1) XOR (taps AND replicate(state[WIDTH-1])), truncated to WIDTH.
- Per enabled cycle, STEPS shifts are chained combinationally. The result is registered: latency 1 cycle, no bubbles.
- Priority per cycle: load > en > hold.
- load=1:
  - out<=seed, start<=seed, counter<=0, period_done<=0
  - en ignored; seed=0 is accepted.
- en=1, load=0, out==0 (lock-up): out<=DEFAULT_SEED, start<=DEFAULT_SEED, counter<=0. No shift; period_done stays 0.
- en=1, load=0, out!=0:
  - out<=next, counter<=counter+1 (saturates at all-ones).
  - If next==start: period_done<=1, period_len<=counter+1, counter<=0. Otherwise period_done<=0.
- en=0, load=0: out, counter and period_len hold; period_done<=0.
- lockup is registered from the next-state value, so it equals (out==0) every cycle.
- taps/mode are sampled every enabled cycle. A change mid-run affects the next shift only; counter and start are not reset.
- Period matching is at cycle granularity. With STEPS>1, a return to start between intra-cycle shifts is not detected; the counter then runs on, saturating.
- Reset asserted mid-operation overrides everything immediately. Deassertion resumes from the DEFAULT_SEED state.

Test Plan:
1. Reset, WIDTH=16, STEPS=1, taps=16'hB400, mode=0, en=1 -> out 0001, 0002, ... after 10 cycles 0400, 11th 0801, 12th 1002.
2. Same config, run 65535 enabled cycles -> period_done pulses exactly once on cycle 65535 with out=0001, period_len=65535; no pulse earlier.
3. load=1, seed=16'h8000, taps=16'h002D, mode=1, then en=1 for one cycle -> out=002D; a second cycle gives 005A.
4. STEPS=2, seed 0001, taps B400, mode 0 -> after 5 enabled cycles out=0400, 6th cycle 1002.
5. load with seed=0 -> lockup=1, out=0000 while en=0. First en cycle -> out=DEFAULT_SEED, lockup=0, period_done=0.
6. Simultaneous load=1,en=1 mid-run -> out=seed, counter cleared. Toggle en low for 3 cycles -> out frozen, period_done=0. Assert nReset asynchronously mid-cycle -> out=0001 before the next clk edge.
